decode_pipe: RTL and testbench
==============================

Name: decode_pipe

Overview:
- Parametrised ID stage with an ID/EX output register; successor to the fixed-width decode stage.
- Owns the register file, with x0 hardwired and write-back bypass.
- Uses a valid/ready handshake on both sides, detects load-use hazards and inserts bubbles, and supports flush.
- Controller and immediate extender are external: their results arrive as a packed control bus and an immediate alongside the instruction.

Parameters:
XLEN, 32, datapath/PC width
AW, 5, register address width; register file has 2**AW entries
CTL_W, 12, width of packed control bus from controller
LOAD_OPCODE, 7'b0000011, opcode marking a memory load

Ports:
clk  in  1  clock, all state updates on rising edge
reset_n  in  1  asynchronous active-low reset
i_valid  in  1  upstream (IF/ID) holds a valid instruction
o_ready  out  1  stage can accept this cycle (combinational)
i_pc  in  XLEN  instruction PC
i_instr  in  32  instruction word; rs1=[19:15], rs2=[24:20], rd=[11:7], opcode=[6:0]
i_ctl  in  CTL_W  control bundle for i_instr
i_imm  in  XLEN  extended immediate for i_instr
i_flush  in  1  kill ID/EX contents (branch/jump taken)
i_wb_en  in  1  write-back enable
i_wb_addr  in  AW  write-back register
i_wb_data  in  XLEN  write-back data
o_valid  out  1  ID/EX register holds a valid instruction
i_ready  in  1  EX accepts this cycle
o_pc  out  XLEN  registered PC
o_imm  out  XLEN  registered immediate
o_rs1_data  out  XLEN  registered rs1 operand
o_rs2_data  out  XLEN  registered rs2 operand
o_rs1  out  AW  registered rs1 index (for EX forwarding)
o_rs2  out  AW  registered rs2 index
o_rd  out  AW  registered destination
o_ctl  out  CTL_W  registered control bundle; all-zero when bubble
o_mem_read  out  1  registered: ID/EX holds a load
o_stall  out  1  load-use hazard this cycle (combinational)

Behaviour:
- Reset (reset_n=0, async): all registered outputs 0, all register-file entries 0. o_ready is 1 from the first cycle after release.
- Register file:
  - Write on the clk edge when i_wb_en=1 and i_wb_addr!=0. Writes to x0 are ignored.
  - Writes occur regardless of stall or flush.
- Reads are combinational from i_instr fields:
  - x0 reads 0.
  - Bypass: if i_wb_en=1, i_wb_addr==rs and rs!=0, read data = i_wb_data (same-cycle write-through).
- Hazard: o_stall = i_valid & o_valid & o_mem_read & (o_rd!=0) & (o_rd==rs1 | o_rd==rs2). No use-flags; both fields are compared unconditionally.
- Ready: o_ready = i_flush | (!o_stall & (!o_valid | i_ready)).
- Accept = i_valid & o_ready & !i_flush. Latency is one cycle from accept to o_valid.
- Per-edge update, priority order:
  1. i_flush=1: o_valid<=0, o_ctl<=0, o_mem_read<=0. Input is consumed and discarded (o_ready=1 lets upstream drain). Other data fields are don't-care.
  2. Accept: load all outputs from the current inputs/read data. o_valid<=1, o_mem_read<=(i_instr[6:0]==LOAD_OPCODE).
  3. o_valid & i_ready with no accept (stall or no input): bubble, i.e. o_valid<=0, o_ctl<=0, o_mem_read<=0.
  4. Otherwise hold all outputs.
- Load-use: the dependent instruction is held upstream for one cycle, the load advances, and one bubble is inserted. The hazard clears because o_valid drops. Net penalty is exactly 1 cycle when i_ready=1.
- While o_valid=1 and i_ready=0, all outputs are stable (hold).
- Operands captured in ID/EX are not updated by later write-backs; EX forwarding resolves these using o_rs1/o_rs2.
- Simultaneous flush and hazard: flush wins, o_stall still reports 1, and o_ready=1.
- Reset asserted mid-operation: immediate clear. Any in-flight instruction is lost with no partial state.

Test Plan:
- Reset, then x5=0x11 via WB; instr add x7,x5,x0 valid with i_ready=1 -> next cycle o_valid=1, o_rs1_data=0x11, o_rs2_data=0, o_rd=7.
- WB x3=0xDEADBEEF in the same cycle an instr reading rs1=x3 is accepted -> o_rs1_data=0xDEADBEEF (bypass). WB to x0 with 0x5 -> later read of x0 = 0.
- lw x4 in ID/EX with o_valid=1, next instr add x6,x4,x1 -> o_stall=1, o_ready=0. Next cycle o_valid=0, o_ctl=0. Following cycle add is accepted, o_rd=6.
- i_ready=0 for 3 cycles with o_valid=1 -> o_pc/o_ctl/o_rs1_data unchanged, o_ready=0. i_ready=1 with i_valid=0 -> o_valid=0 next cycle.
- i_flush=1 with o_valid=1 and i_valid=1 -> o_ready=1, next cycle o_valid=0, o_ctl=0, o_mem_read=0. Flush coinciding with a load-use hazard gives the same result.
- reset_n pulsed low mid-stream between edges -> outputs 0 immediately and register file cleared. After release, o_ready=1.

Source files
------------

// File: rtl/decode_pipe.sv
// decode_pipe: ID stage with register file (x0 hardwired, write-back bypass), load-use detection and ID/EX register.
// Latency: one cycle from accept (i_valid & o_ready & !i_flush) to o_valid.
// Backpressure: ID/EX holds while i_ready=0; o_ready drops on hold or load-use hazard; flush always drains upstream.
//
// Ports:
//   clk, reset_n                      clock, async active-low reset
//   i_valid/o_ready                   upstream handshake (IF/ID -> ID)
//   i_pc, i_instr, i_ctl, i_imm       instruction, PC, controller bundle, extended immediate
//   i_flush                           kill ID/EX contents and discard the incoming instruction
//   i_wb_en, i_wb_addr, i_wb_data     register file write-back port
//   o_valid/i_ready                   downstream handshake (ID/EX -> EX)
//   o_pc, o_imm, o_rs1_data, o_rs2_data, o_rs1, o_rs2, o_rd, o_ctl, o_mem_read   ID/EX register
//   o_stall                           load-use hazard this cycle
module decode_pipe #(
    parameter int         XLEN        = 32,
    parameter int         AW          = 5,
    parameter int         CTL_W       = 12,
    parameter logic [6:0] LOAD_OPCODE = 7'b0000011
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [XLEN-1:0]  i_pc,
    input  logic [31:0]      i_instr,
    input  logic [CTL_W-1:0] i_ctl,
    input  logic [XLEN-1:0]  i_imm,
    input  logic             i_flush,
    input  logic             i_wb_en,
    input  logic [AW-1:0]    i_wb_addr,
    input  logic [XLEN-1:0]  i_wb_data,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [XLEN-1:0]  o_pc,
    output logic [XLEN-1:0]  o_imm,
    output logic [XLEN-1:0]  o_rs1_data,
    output logic [XLEN-1:0]  o_rs2_data,
    output logic [AW-1:0]    o_rs1,
    output logic [AW-1:0]    o_rs2,
    output logic [AW-1:0]    o_rd,
    output logic [CTL_W-1:0] o_ctl,
    output logic             o_mem_read,
    output logic             o_stall
);
    localparam int NREG = 2**AW;

    logic [XLEN-1:0]  r_rf [NREG];

    logic             r_valid;
    logic [XLEN-1:0]  r_pc;
    logic [XLEN-1:0]  r_imm;
    logic [XLEN-1:0]  r_rs1_data;
    logic [XLEN-1:0]  r_rs2_data;
    logic [AW-1:0]    r_rs1;
    logic [AW-1:0]    r_rs2;
    logic [AW-1:0]    r_rd;
    logic [CTL_W-1:0] r_ctl;
    logic             r_mem_read;

    logic [AW-1:0]    w_rs1;
    logic [AW-1:0]    w_rs2;
    logic [AW-1:0]    w_rd;
    logic [6:0]       w_opcode;
    logic [XLEN-1:0]  w_rs1_data;
    logic [XLEN-1:0]  w_rs2_data;
    logic             w_stall;
    logic             w_ready;
    logic             w_accept;
    logic             w_unused;

    assign w_rs1    = AW'(i_instr[19:15]);
    assign w_rs2    = AW'(i_instr[24:20]);
    assign w_rd     = AW'(i_instr[11:7]);
    assign w_opcode = i_instr[6:0];
    // funct fields are decoded by the external controller
    assign w_unused = ^{i_instr[31:25], i_instr[14:12]};

    // Register file: x0 is never written; writes proceed independent of stall/flush.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < NREG; i++) begin
                r_rf[i] <= '0;
            end
        end else if (i_wb_en && (i_wb_addr != '0)) begin
            r_rf[i_wb_addr] <= i_wb_data;
        end
    end

    // Read ports with same-cycle write-through so WB and ID can overlap.
    always_comb begin
        w_rs1_data = r_rf[w_rs1];
        if (w_rs1 == '0) begin
            w_rs1_data = '0;
        end else if (i_wb_en && (i_wb_addr == w_rs1)) begin
            w_rs1_data = i_wb_data;
        end
    end

    always_comb begin
        w_rs2_data = r_rf[w_rs2];
        if (w_rs2 == '0) begin
            w_rs2_data = '0;
        end else if (i_wb_en && (i_wb_addr == w_rs2)) begin
            w_rs2_data = i_wb_data;
        end
    end

    // Both source fields compared unconditionally: a false hazard costs one bubble, never correctness.
    assign w_stall  = i_valid & r_valid & r_mem_read & (r_rd != '0) &
                      ((r_rd == w_rs1) | (r_rd == w_rs2));
    assign w_ready  = i_flush | (~w_stall & (~r_valid | i_ready));
    assign w_accept = i_valid & w_ready & ~i_flush;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_valid    <= 1'b0;
            r_pc       <= '0;
            r_imm      <= '0;
            r_rs1_data <= '0;
            r_rs2_data <= '0;
            r_rs1      <= '0;
            r_rs2      <= '0;
            r_rd       <= '0;
            r_ctl      <= '0;
            r_mem_read <= 1'b0;
        end else if (i_flush) begin
            r_valid    <= 1'b0;
            r_ctl      <= '0;
            r_mem_read <= 1'b0;
        end else if (w_accept) begin
            r_valid    <= 1'b1;
            r_pc       <= i_pc;
            r_imm      <= i_imm;
            r_rs1_data <= w_rs1_data;
            r_rs2_data <= w_rs2_data;
            r_rs1      <= w_rs1;
            r_rs2      <= w_rs2;
            r_rd       <= w_rd;
            r_ctl      <= i_ctl;
            r_mem_read <= (w_opcode == LOAD_OPCODE);
        end else if (r_valid && i_ready) begin
            // Drained with nothing to replace it: insert a bubble.
            r_valid    <= 1'b0;
            r_ctl      <= '0;
            r_mem_read <= 1'b0;
        end
    end

    assign o_ready    = w_ready;
    assign o_stall    = w_stall;
    assign o_valid    = r_valid;
    assign o_pc       = r_pc;
    assign o_imm      = r_imm;
    assign o_rs1_data = r_rs1_data;
    assign o_rs2_data = r_rs2_data;
    assign o_rs1      = r_rs1;
    assign o_rs2      = r_rs2;
    assign o_rd       = r_rd;
    assign o_ctl      = r_ctl;
    assign o_mem_read = r_mem_read;

endmodule

// File: tb/tb_decode_pipe.sv
// tb_decode_pipe: scoreboard bench for decode_pipe.
// Latency: expects ID/EX output one cycle after each accept.
// Backpressure: drives i_ready patterns including random stalls.
module tb_decode_pipe;
    localparam int         XLEN    = 32;
    localparam int         AW      = 5;
    localparam int         CTL_W   = 12;
    localparam logic [6:0] OP_LOAD = 7'b0000011;
    localparam logic [6:0] OP_ADD  = 7'b0110011;

    logic             clk;
    logic             reset_n;
    logic             i_valid;
    logic             o_ready;
    logic [XLEN-1:0]  i_pc;
    logic [31:0]      i_instr;
    logic [CTL_W-1:0] i_ctl;
    logic [XLEN-1:0]  i_imm;
    logic             i_flush;
    logic             i_wb_en;
    logic [AW-1:0]    i_wb_addr;
    logic [XLEN-1:0]  i_wb_data;
    logic             o_valid;
    logic             i_ready;
    logic [XLEN-1:0]  o_pc;
    logic [XLEN-1:0]  o_imm;
    logic [XLEN-1:0]  o_rs1_data;
    logic [XLEN-1:0]  o_rs2_data;
    logic [AW-1:0]    o_rs1;
    logic [AW-1:0]    o_rs2;
    logic [AW-1:0]    o_rd;
    logic [CTL_W-1:0] o_ctl;
    logic             o_mem_read;
    logic             o_stall;

    decode_pipe #(.XLEN(XLEN), .AW(AW), .CTL_W(CTL_W), .LOAD_OPCODE(OP_LOAD)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .i_valid    (i_valid),
        .o_ready    (o_ready),
        .i_pc       (i_pc),
        .i_instr    (i_instr),
        .i_ctl      (i_ctl),
        .i_imm      (i_imm),
        .i_flush    (i_flush),
        .i_wb_en    (i_wb_en),
        .i_wb_addr  (i_wb_addr),
        .i_wb_data  (i_wb_data),
        .o_valid    (o_valid),
        .i_ready    (i_ready),
        .o_pc       (o_pc),
        .o_imm      (o_imm),
        .o_rs1_data (o_rs1_data),
        .o_rs2_data (o_rs2_data),
        .o_rs1      (o_rs1),
        .o_rs2      (o_rs2),
        .o_rd       (o_rd),
        .o_ctl      (o_ctl),
        .o_mem_read (o_mem_read),
        .o_stall    (o_stall)
    );

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] imm;
        logic [31:0] rs1d;
        logic [31:0] rs2d;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [4:0]  rd;
        logic [11:0] ctl;
        logic        mem;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_exp;
    exp_t        mon_got;
    exp_t        drop;
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] mrf [32];

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Reference register file
    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 32; i++) mrf[i] <= '0;
        end else if (i_wb_en && i_wb_addr != 5'd0) begin
            mrf[i_wb_addr] <= i_wb_data;
        end
    end

    function automatic logic [31:0] model_rd(input logic [4:0] a);
        if (a == 5'd0) return 32'd0;
        if (i_wb_en && i_wb_addr == a) return i_wb_data;
        return mrf[a];
    endfunction

    function automatic logic [31:0] mk(input logic [6:0] op, input logic [4:0] rd,
                                       input logic [4:0] rs1, input logic [4:0] rs2);
        return {7'd0, rs2, rs1, 3'd0, rd, op};
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] pc, input logic [31:0] instr,
                         input logic [11:0] ctl, input logic [31:0] imm);
        i_valid = 1'b1;
        i_pc    = pc;
        i_instr = instr;
        i_ctl   = ctl;
        i_imm   = imm;
    endtask

    task automatic idle();
        i_valid = 1'b0;
        i_pc    = '0;
        i_instr = '0;
        i_ctl   = '0;
        i_imm   = '0;
    endtask

    // Record the expected ID/EX contents for the instruction currently on the inputs.
    task automatic push_exp();
        exp_t e;
        e.pc   = i_pc;
        e.imm  = i_imm;
        e.rs1  = i_instr[19:15];
        e.rs2  = i_instr[24:20];
        e.rd   = i_instr[11:7];
        e.rs1d = model_rd(i_instr[19:15]);
        e.rs2d = model_rd(i_instr[24:20]);
        e.ctl  = i_ctl;
        e.mem  = (i_instr[6:0] == OP_LOAD);
        sb.push_back(e);
    endtask

    // Scoreboard: compare whenever EX consumes the ID/EX register.
    always @(negedge clk) begin
        if (reset_n && o_valid && i_ready && !i_flush) begin
            checks++;
            if (sb.size() == 0) begin
                failures++;
                $display("FAIL sb_unexpected output pc=%h rd=%0d with empty scoreboard", o_pc, o_rd);
            end else begin
                mon_exp      = sb.pop_front();
                mon_got.pc   = o_pc;
                mon_got.imm  = o_imm;
                mon_got.rs1d = o_rs1_data;
                mon_got.rs2d = o_rs2_data;
                mon_got.rs1  = o_rs1;
                mon_got.rs2  = o_rs2;
                mon_got.rd   = o_rd;
                mon_got.ctl  = o_ctl;
                mon_got.mem  = o_mem_read;
                if (mon_got !== mon_exp) begin
                    failures++;
                    $display("FAIL sb_idex got pc=%h imm=%h a=%h b=%h rs1=%0d rs2=%0d rd=%0d ctl=%h mem=%b exp pc=%h imm=%h a=%h b=%h rs1=%0d rs2=%0d rd=%0d ctl=%h mem=%b",
                             mon_got.pc, mon_got.imm, mon_got.rs1d, mon_got.rs2d, mon_got.rs1, mon_got.rs2, mon_got.rd, mon_got.ctl, mon_got.mem,
                             mon_exp.pc, mon_exp.imm, mon_exp.rs1d, mon_exp.rs2d, mon_exp.rs1, mon_exp.rs2, mon_exp.rd, mon_exp.ctl, mon_exp.mem);
                end
            end
        end
    end

    task automatic test_reset();
        reset_n = 1'b0;
        i_flush = 1'b0; i_wb_en = 1'b0; i_wb_addr = '0; i_wb_data = '0; i_ready = 1'b0;
        idle();
        repeat (2) tick();
        checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", o_valid); end
        checks++; if (o_pc !== 32'd0) begin failures++; $display("FAIL reset_pc got=%h exp=0", o_pc); end
        checks++; if (o_ctl !== 12'd0 || o_mem_read !== 1'b0) begin failures++; $display("FAIL reset_ctl got=%h/%b exp=0/0", o_ctl, o_mem_read); end
        checks++; if (o_rs1_data !== 32'd0 || o_rd !== 5'd0) begin failures++; $display("FAIL reset_data got=%h/%0d exp=0/0", o_rs1_data, o_rd); end
        reset_n = 1'b1;
        tick();
        checks++; if (o_ready !== 1'b1) begin failures++; $display("FAIL reset_ready got=%b exp=1", o_ready); end
    endtask

    task automatic test_basic();
        i_ready = 1'b1;
        i_wb_en = 1'b1; i_wb_addr = 5'd5; i_wb_data = 32'h11;
        tick();
        i_wb_en = 1'b0;
        drive(32'h1000, mk(OP_ADD, 5'd7, 5'd5, 5'd0), 12'h021, 32'h0);
        push_exp();
        tick();
        idle();
        checks++; if (o_valid !== 1'b1) begin failures++; $display("FAIL basic_valid got=%b exp=1", o_valid); end
        checks++; if (o_rs1_data !== 32'h11) begin failures++; $display("FAIL basic_rs1 got=%h exp=00000011", o_rs1_data); end
        checks++; if (o_rs2_data !== 32'h0) begin failures++; $display("FAIL basic_rs2 got=%h exp=0", o_rs2_data); end
        checks++; if (o_rd !== 5'd7) begin failures++; $display("FAIL basic_rd got=%0d exp=7", o_rd); end
        tick();
        checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL basic_drain got=%b exp=0", o_valid); end
    endtask

    task automatic test_bypass();
        i_ready = 1'b1;
        drive(32'h1010, mk(OP_ADD, 5'd8, 5'd3, 5'd0), 12'h022, 32'h0);
        i_wb_en = 1'b1; i_wb_addr = 5'd3; i_wb_data = 32'hDEADBEEF;
        push_exp();
        tick();
        checks++; if (o_rs1_data !== 32'hDEADBEEF) begin failures++; $display("FAIL bypass_rs1 got=%h exp=deadbeef", o_rs1_data); end
        drive(32'h1014, mk(OP_ADD, 5'd9, 5'd0, 5'd3), 12'h023, 32'h0);
        i_wb_en = 1'b1; i_wb_addr = 5'd0; i_wb_data = 32'h5;
        push_exp();
        tick();
        checks++; if (o_rs1_data !== 32'h0) begin failures++; $display("FAIL bypass_x0 got=%h exp=0", o_rs1_data); end
        checks++; if (o_rs2_data !== 32'hDEADBEEF) begin failures++; $display("FAIL rf_read_x3 got=%h exp=deadbeef", o_rs2_data); end
        i_wb_en = 1'b0;
        drive(32'h1018, mk(OP_ADD, 5'd10, 5'd0, 5'd0), 12'h024, 32'h0);
        push_exp();
        tick();
        checks++; if (o_rs1_data !== 32'h0) begin failures++; $display("FAIL x0_after_wb got=%h exp=0", o_rs1_data); end
        idle();
        tick();
    endtask

    task automatic test_load_use();
        i_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            logic [4:0] lr;
            lr = (k == 0) ? 5'd4 : 5'd9;
            drive(32'h100 + 32'(k * 16), mk(OP_LOAD, lr, 5'd2, 5'd0), 12'h100, 32'h8);
            push_exp();
            tick();
            checks++; if (o_mem_read !== 1'b1) begin failures++; $display("FAIL lu_memread k=%0d got=%b exp=1", k, o_mem_read); end
            drive(32'h104 + 32'(k * 16), (k == 0) ? mk(OP_ADD, 5'd6, lr, 5'd1) : mk(OP_ADD, 5'd6, 5'd1, lr), 12'h001, 32'h0);
            #1;
            checks++; if (o_stall !== 1'b1 || o_ready !== 1'b0) begin failures++; $display("FAIL lu_stall k=%0d got stall=%b ready=%b exp 1/0", k, o_stall, o_ready); end
            tick();
            checks++; if (o_valid !== 1'b0 || o_ctl !== 12'd0) begin failures++; $display("FAIL lu_bubble k=%0d got valid=%b ctl=%h exp 0/000", k, o_valid, o_ctl); end
            checks++; if (o_stall !== 1'b0 || o_ready !== 1'b1) begin failures++; $display("FAIL lu_clear k=%0d got stall=%b ready=%b exp 0/1", k, o_stall, o_ready); end
            push_exp();
            tick();
            idle();
            checks++; if (o_valid !== 1'b1 || o_rd !== 5'd6) begin failures++; $display("FAIL lu_accept k=%0d got valid=%b rd=%0d exp 1/6", k, o_valid, o_rd); end
            tick();
        end
        // Load to x0 never creates a hazard
        drive(32'h140, mk(OP_LOAD, 5'd0, 5'd2, 5'd0), 12'h100, 32'h0);
        push_exp();
        tick();
        drive(32'h144, mk(OP_ADD, 5'd6, 5'd0, 5'd0), 12'h001, 32'h0);
        #1;
        checks++; if (o_stall !== 1'b0 || o_ready !== 1'b1) begin failures++; $display("FAIL lu_x0 got stall=%b ready=%b exp 0/1", o_stall, o_ready); end
        push_exp();
        tick();
        idle();
        checks++; if (o_valid !== 1'b1 || o_rd !== 5'd6) begin failures++; $display("FAIL lu_x0_accept got valid=%b rd=%0d exp 1/6", o_valid, o_rd); end
        tick();
    endtask

    task automatic test_hold();
        i_ready = 1'b1;
        i_wb_en = 1'b1; i_wb_addr = 5'd12; i_wb_data = 32'h1234;
        tick();
        i_wb_en = 1'b0;
        drive(32'h200, mk(OP_ADD, 5'd13, 5'd12, 5'd0), 12'hABC, 32'h55);
        push_exp();
        tick();
        i_ready = 1'b0;
        drive(32'h204, mk(OP_ADD, 5'd14, 5'd1, 5'd2), 12'h005, 32'h0);
        i_wb_en = 1'b1; i_wb_addr = 5'd12; i_wb_data = 32'h9999;
        repeat (3) begin
            #1;
            checks++; if (o_ready !== 1'b0) begin failures++; $display("FAIL hold_ready got=%b exp=0", o_ready); end
            tick();
            i_wb_en = 1'b0;
            checks++; if (o_valid !== 1'b1 || o_pc !== 32'h200 || o_ctl !== 12'hABC || o_rs1_data !== 32'h1234) begin
                failures++; $display("FAIL hold_stable got valid=%b pc=%h ctl=%h a=%h exp 1/200/abc/1234", o_valid, o_pc, o_ctl, o_rs1_data);
            end
        end
        i_ready = 1'b1;
        idle();
        tick();
        checks++; if (o_valid !== 1'b0) begin failures++; $display("FAIL hold_release got=%b exp=0", o_valid); end
    endtask

    task automatic test_flush();
        for (int k = 0; k < 2; k++) begin
            i_ready = 1'b0;
            drive(32'h300 + 32'(k * 16), mk(OP_LOAD, 5'd8, 5'd2, 5'd0), 12'h200, 32'h4);
            push_exp();
            tick();
            checks++; if (o_valid !== 1'b1) begin failures++; $display("FAIL flush_setup k=%0d got=%b exp=1", k, o_valid); end
            drive(32'h304 + 32'(k * 16), (k == 1) ? mk(OP_ADD, 5'd10, 5'd8, 5'd1) : mk(OP_ADD, 5'd10, 5'd1, 5'd2), 12'h003, 32'h0);
            i_flush = 1'b1;
            #1;
            checks++; if (o_ready !== 1'b1 || o_stall !== (k == 1)) begin failures++; $display("FAIL flush_ready k=%0d got ready=%b stall=%b exp 1/%0d", k, o_ready, o_stall, k); end
            drop = sb.pop_front();
            tick();
            i_flush = 1'b0;
            idle();
            checks++; if (o_valid !== 1'b0 || o_ctl !== 12'd0 || o_mem_read !== 1'b0) begin
                failures++; $display("FAIL flush_clear k=%0d got valid=%b ctl=%h mem=%b exp 0/000/0", k, o_valid, o_ctl, o_mem_read);
            end
        end
    endtask

    task automatic test_back_to_back();
        logic mv;
        int   n;
        mv = 1'b0;
        n  = 0;
        for (int cyc = 0; cyc < 60 && n < 8; cyc++) begin
            logic exp_rdy;
            i_ready = 1'($urandom_range(0, 1));
            drive(32'h400 + 32'(n * 4), mk(OP_ADD, 5'(16 + n), 5'(n), 5'(n + 1)), 12'(n + 1), 32'(n * 3));
            exp_rdy = !mv || i_ready;
            #1;
            checks++; if (o_ready !== exp_rdy) begin failures++; $display("FAIL b2b_ready cyc=%0d got=%b exp=%b", cyc, o_ready, exp_rdy); end
            if (exp_rdy) push_exp();
            tick();
            if (exp_rdy) begin
                mv = 1'b1;
                n++;
            end else if (i_ready) begin
                mv = 1'b0;
            end
        end
        i_ready = 1'b1;
        idle();
        repeat (2) tick();
    endtask

    task automatic test_reset_mid();
        i_ready = 1'b0;
        i_wb_en = 1'b1; i_wb_addr = 5'd20; i_wb_data = 32'hCAFE;
        tick();
        i_wb_en = 1'b0;
        drive(32'h500, mk(OP_ADD, 5'd21, 5'd20, 5'd3), 12'h077, 32'h9);
        push_exp();
        tick();
        idle();
        #2;
        reset_n = 1'b0;
        #1;
        checks++; if (o_valid !== 1'b0 || o_pc !== 32'd0 || o_rs1_data !== 32'd0 || o_rd !== 5'd0 || o_ctl !== 12'd0) begin
            failures++; $display("FAIL midreset_clear got valid=%b pc=%h a=%h rd=%0d ctl=%h exp all 0", o_valid, o_pc, o_rs1_data, o_rd, o_ctl);
        end
        sb.delete();
        i_ready = 1'b1;
        tick();
        reset_n = 1'b1;
        tick();
        checks++; if (o_ready !== 1'b1) begin failures++; $display("FAIL midreset_ready got=%b exp=1", o_ready); end
        drive(32'h600, mk(OP_ADD, 5'd22, 5'd20, 5'd3), 12'h078, 32'h0);
        push_exp();
        tick();
        idle();
        checks++; if (o_rs1_data !== 32'd0 || o_rs2_data !== 32'd0) begin failures++; $display("FAIL midreset_rf got a=%h b=%h exp 0/0", o_rs1_data, o_rs2_data); end
        tick();
    endtask

    initial begin
        test_reset();
        test_basic();
        test_bypass();
        test_load_use();
        test_hold();
        test_flush();
        test_back_to_back();
        test_reset_mid();
        checks++; if (sb.size() != 0) begin failures++; $display("FAIL sb_leftover got=%0d exp=0", sb.size()); end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
